eviction_buffer: RTL and testbench

// Single-entry write-back buffer between the cache controller's pmem port and physical memory.

---
 rtl/eviction_buffer.sv | 136 +++++++++++++
 tb/tb_eviction_buffer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eviction_buffer.sv
// Single-entry write-back buffer between a cache's pmem port and physical memory.
// Absorbs one evicted line, serves read hits locally and drains the line while the cache is idle.
`timescale 1ns/1ps

module eviction_buffer #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 256,
    parameter int OFFSET_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cache_pmem_read,
    input  logic                  cache_pmem_write,
    input  logic [ADDR_WIDTH-1:0] cache_pmem_address,
    input  logic [LINE_WIDTH-1:0] cache_pmem_wdata,
    output logic [LINE_WIDTH-1:0] cache_pmem_rdata,
    output logic                  cache_pmem_resp,
    input  logic                  idle,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    localparam int TAG_WIDTH = ADDR_WIDTH - OFFSET_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESP,
        S_RD_MEM,
        S_DRAIN
    } state_e;

    state_e                state_q, state_d;
    logic                  buf_valid_q, buf_valid_d;
    logic [TAG_WIDTH-1:0]  buf_tag_q, buf_tag_d;
    logic [LINE_WIDTH-1:0] buf_data_q, buf_data_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;

    logic [TAG_WIDTH-1:0]  req_tag;
    logic                  hit;
    logic                  unused_offset;

    assign req_tag       = cache_pmem_address[ADDR_WIDTH-1:OFFSET_BITS];
    assign hit           = buf_valid_q && (req_tag == buf_tag_q);
    assign unused_offset = ^cache_pmem_address[OFFSET_BITS-1:0];

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can infer a latch.
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        rdata_d     = rdata_q;

        case (state_q)
            S_IDLE: begin
                // A read wins over a simultaneous write; a write into a full buffer drains first and retries.
                if (cache_pmem_read) begin
                    if (hit) begin
                        rdata_d = buf_data_q;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_RD_MEM;
                    end
                end else if (cache_pmem_write) begin
                    if (!buf_valid_q) begin
                        buf_valid_d = 1'b1;
                        buf_tag_d   = req_tag;
                        buf_data_d  = cache_pmem_wdata;
                        state_d     = S_RESP;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (buf_valid_q && idle) begin
                    state_d = S_DRAIN;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            S_RD_MEM: begin
                if (mem_resp) begin
                    rdata_d = mem_rdata;
                    state_d = S_RESP;
                end
            end
            S_DRAIN: begin
                if (mem_resp) begin
                    buf_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            // NOTE: the wide line registers are reset on purpose: outputs must read zero after reset.
            buf_data_q  <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
            rdata_q     <= rdata_d;
        end
    end

    // Handshake strobes come from the state register alone.
    assign cache_pmem_resp  = (state_q == S_RESP);
    assign mem_read         = (state_q == S_RD_MEM);
    assign mem_write        = (state_q == S_DRAIN);
    assign cache_pmem_rdata = rdata_q;
    assign mem_wdata        = buf_data_q;

    always_comb begin
        mem_address = '0;
        case (state_q)
            S_RD_MEM: mem_address = {req_tag, {OFFSET_BITS{1'b0}}};
            S_DRAIN:  mem_address = {buf_tag_q, {OFFSET_BITS{1'b0}}};
            default:  mem_address = '0;
        endcase
    end

endmodule

// File: tb/tb_eviction_buffer.sv
// Self-checking bench for eviction_buffer: directed scenarios plus random traffic
// against a transaction-level model of the buffer and of physical memory.
`timescale 1ns/1ps

module tb_eviction_buffer;

    localparam int AW     = 32;
    localparam int LW     = 256;
    localparam int OB     = 5;
    localparam int BUDGET = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          cache_pmem_read;
    logic          cache_pmem_write;
    logic [AW-1:0] cache_pmem_address;
    logic [LW-1:0] cache_pmem_wdata;
    logic [LW-1:0] cache_pmem_rdata;
    logic          cache_pmem_resp;
    logic          idle;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;

    always #5 clk = ~clk;

    eviction_buffer #(
        .ADDR_WIDTH (AW),
        .LINE_WIDTH (LW),
        .OFFSET_BITS(OB)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cache_pmem_read   (cache_pmem_read),
        .cache_pmem_write  (cache_pmem_write),
        .cache_pmem_address(cache_pmem_address),
        .cache_pmem_wdata  (cache_pmem_wdata),
        .cache_pmem_rdata  (cache_pmem_rdata),
        .cache_pmem_resp   (cache_pmem_resp),
        .idle              (idle),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_address       (mem_address),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_resp          (mem_resp)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
        int            cycles;
    } mem_txn_t;

    mem_txn_t      wr_log[$];
    mem_txn_t      rd_log[$];
    logic [LW-1:0] phys_mem[logic [AW-1:0]];
    logic [LW-1:0] ref_mem[logic [AW-1:0]];

    // Reference model of the buffer: one optional dirty line.
    bit            ref_valid = 1'b0;
    logic [AW-1:0] ref_line  = '0;
    logic [LW-1:0] ref_data  = '0;

    function automatic logic [LW-1:0] line_pattern(input logic [AW-1:0] a);
        return {8{a ^ 32'h5A5A_C3C3}};
    endfunction

    function automatic logic [LW-1:0] phys_fetch(input logic [AW-1:0] a);
        if (phys_mem.exists(a)) return phys_mem[a];
        return line_pattern(a);
    endfunction

    function automatic logic [LW-1:0] ref_fetch(input logic [AW-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return line_pattern(a);
    endfunction

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return {a[AW-1:OB], {OB{1'b0}}};
    endfunction

    // Memory responder: answers after mem_lat strobe cycles unless mem_hold is set.
    int mem_lat       = 1;
    bit mem_hold      = 1'b0;
    int strobe_cycles = 0;
    int if_viol       = 0;

    initial begin
        mem_resp  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_read && mem_write) if_viol++;
            if (!(mem_read || mem_write) && mem_address != '0) if_viol++;
            if (mem_address[OB-1:0] != '0) if_viol++;
            if (mem_resp) begin
                mem_resp      = 1'b0;
                mem_rdata     = {8{$urandom}};
                strobe_cycles = 0;
            end else if (mem_read || mem_write) begin
                strobe_cycles++;
                if (!mem_hold && strobe_cycles >= mem_lat) begin
                    mem_resp = 1'b1;
                    if (mem_write) begin
                        phys_mem[mem_address] = mem_wdata;
                        wr_log.push_back('{mem_address, mem_wdata, strobe_cycles});
                    end else begin
                        mem_rdata = phys_fetch(mem_address);
                        rd_log.push_back('{mem_address, mem_rdata, strobe_cycles});
                    end
                end
            end else begin
                strobe_cycles = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        for (int i = 1; i <= BUDGET; i++) begin
            tick();
            if (cache_pmem_resp) begin
                cycles = i;
                ok     = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int lat);
        logic [AW-1:0] line;
        bit            hit;
        logic [LW-1:0] exp;
        int            exp_lat, rd_before, wr_before, cyc;
        bit            ok;
        line      = align(addr);
        hit       = ref_valid && (ref_line == line);
        exp       = hit ? ref_data : ref_fetch(line);
        exp_lat   = hit ? 1 : lat + 1;
        rd_before = rd_log.size();
        wr_before = wr_log.size();
        mem_lat   = lat;
        cache_pmem_read    = 1'b1;
        cache_pmem_address = addr;
        wait_resp(cyc, ok);
        cache_pmem_read    = 1'b0;
        cache_pmem_address = $urandom;
        check("rd_resp_seen", LW'(ok), LW'(1));
        check("rd_latency", LW'(cyc), LW'(exp_lat));
        check("rd_data", cache_pmem_rdata, exp);
        check("rd_mem_reads", LW'(rd_log.size() - rd_before), LW'(hit ? 0 : 1));
        check("rd_mem_writes", LW'(wr_log.size() - wr_before), LW'(0));
        if (!hit && rd_log.size() > rd_before) begin
            check("rd_mem_addr", LW'(rd_log[rd_before].addr), LW'(line));
            check("rd_strobe_len", LW'(rd_log[rd_before].cycles), LW'(lat));
        end
        tick();
        check("rd_resp_pulse", LW'(cache_pmem_resp), LW'(0));
        check("rd_rdata_hold", cache_pmem_rdata, exp);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [LW-1:0] data, input int lat);
        bit full;
        int exp_lat, rd_before, wr_before, cyc;
        bit ok;
        full      = ref_valid;
        exp_lat   = full ? lat + 2 : 1;
        rd_before = rd_log.size();
        wr_before = wr_log.size();
        mem_lat   = lat;
        cache_pmem_write   = 1'b1;
        cache_pmem_address = addr;
        cache_pmem_wdata   = data;
        wait_resp(cyc, ok);
        cache_pmem_write   = 1'b0;
        cache_pmem_address = $urandom;
        cache_pmem_wdata   = {8{$urandom}};
        check("wr_resp_seen", LW'(ok), LW'(1));
        check("wr_latency", LW'(cyc), LW'(exp_lat));
        check("wr_mem_writes", LW'(wr_log.size() - wr_before), LW'(full ? 1 : 0));
        check("wr_mem_reads", LW'(rd_log.size() - rd_before), LW'(0));
        if (full && wr_log.size() > wr_before) begin
            check("wr_drain_addr", LW'(wr_log[wr_before].addr), LW'(ref_line));
            check("wr_drain_data", wr_log[wr_before].data, ref_data);
        end
        if (full) ref_mem[ref_line] = ref_data;
        ref_valid = 1'b1;
        ref_line  = align(addr);
        ref_data  = data;
        tick();
        check("wr_resp_pulse", LW'(cache_pmem_resp), LW'(0));
    endtask

    task automatic do_idle(input int n, input int lat);
        bit will;
        int wr_before;
        will      = ref_valid;
        wr_before = wr_log.size();
        mem_lat   = lat;
        idle      = 1'b1;
        repeat (n) tick();
        idle = 1'b0;
        for (int i = 0; i < BUDGET && mem_write; i++) tick();
        check("drain_done", LW'(mem_write), LW'(0));
        check("drain_count", LW'(wr_log.size() - wr_before), LW'(will ? 1 : 0));
        if (will && wr_log.size() > wr_before) begin
            check("drain_addr", LW'(wr_log[wr_before].addr), LW'(ref_line));
            check("drain_data", wr_log[wr_before].data, ref_data);
            check("drain_strobe_len", LW'(wr_log[wr_before].cycles), LW'(lat));
        end
        if (will) ref_mem[ref_line] = ref_data;
        ref_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_resp"}, LW'(cache_pmem_resp), LW'(0));
        check({tag, "_mem_read"}, LW'(mem_read), LW'(0));
        check({tag, "_mem_write"}, LW'(mem_write), LW'(0));
        check({tag, "_mem_address"}, LW'(mem_address), LW'(0));
        check({tag, "_mem_wdata"}, mem_wdata, LW'(0));
        check({tag, "_rdata"}, cache_pmem_rdata, LW'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a_addr, b_addr;
        logic [LW-1:0] d1, d2, d3;
        a_addr = 32'h0000_1040;
        b_addr = 32'h0000_3000;
        d1     = {8{32'hD1D1_0001}};
        d2     = {8{32'hD2D2_0002}};
        d3     = {8{32'hD3D3_0003}};

        rst                = 1'b1;
        cache_pmem_read    = 1'b0;
        cache_pmem_write   = 1'b0;
        cache_pmem_address = '0;
        cache_pmem_wdata   = '0;
        idle               = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Absorb into empty buffer, hit on another offset of the same line, then drain on idle.
        do_write(a_addr, d1, 3);
        do_read(32'h0000_105C, 3);
        do_idle(2, 3);

        // Read miss with a five-cycle memory.
        do_read(32'h0000_2000, 5);

        // Write while full: old line drains before the new one is captured.
        do_write(a_addr, d1, 2);
        do_write(b_addr, d2, 4);
        do_read(b_addr, 2);
        do_idle(1, 2);

        // Reset in the middle of a drain discards the dirty line.
        do_write(a_addr, d3, 1);
        mem_hold = 1'b1;
        idle     = 1'b1;
        tick();
        idle = 1'b0;
        tick();
        tick();
        check("pre_reset_drain", LW'(mem_write), LW'(1));
        rst = 1'b1;
        tick();
        check_all_zero("mid_drain_reset");
        rst       = 1'b0;
        mem_hold  = 1'b0;
        ref_valid = 1'b0;
        tick();
        do_read(a_addr, 2);

        // idle falls one cycle after the drain starts; the drain must still complete.
        do_write(32'h0000_4020, d2, 1);
        do_idle(1, 4);

        for (int k = 0; k < 200; k++) begin
            logic [AW-1:0] addr;
            int            op, lat;
            addr = 32'h0004_0000 + (AW'($urandom_range(0, 3)) << OB) + AW'($urandom_range(0, 31));
            lat  = $urandom_range(1, 5);
            op   = $urandom_range(0, 9);
            if (op <= 4)      do_read(addr, lat);
            else if (op <= 7) do_write(addr, {8{$urandom}}, lat);
            else              do_idle($urandom_range(1, 3), lat);
        end

        do_idle(2, 1);
        check("mem_if_rules", LW'(if_viol), LW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
